keypad_scan_debounce: RTL and testbench

KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

---
 rtl/keypad_scan_debounce.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner with frame-level debounce.
// Rows rotate free-running; one classified frame per four rows.
module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {
    IDLE, DEB, PRESSED, REL
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  col_s1, col_s2;
  logic [15:0] div;
  logic [1:0]  row;
  logic [1:0]  acc_n;
  logic [3:0]  acc_code;
  logic [3:0]  cnt, cnt_nx;
  logic [3:0]  cand, cand_nx;
  logic        sample, frame_end;
  logic        accept, release_ok;
  logic [3:0]  lows;
  logic [2:0]  rcnt;
  logic [1:0]  rcol;
  logic [1:0]  base_n, tot_n;
  logic [2:0]  sum_n;
  logic [3:0]  base_code, f_code;
  logic        f_key;

  function automatic logic [3:0] key_map(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] v;
    unique case ({r, c})
      4'd0:    v = 4'd1;
      4'd1:    v = 4'd2;
      4'd2:    v = 4'd3;
      4'd3:    v = 4'd10;
      4'd4:    v = 4'd4;
      4'd5:    v = 4'd5;
      4'd6:    v = 4'd6;
      4'd7:    v = 4'd11;
      4'd8:    v = 4'd7;
      4'd9:    v = 4'd8;
      4'd10:   v = 4'd9;
      4'd11:   v = 4'd12;
      4'd12:   v = 4'd14;
      4'd13:   v = 4'd0;
      4'd14:   v = 4'd13;
      default: v = 4'd15;
    endcase
    return v;
  endfunction

  assign row_out   = ~(4'b0001 << row);
  assign sample    = (div == 16'(SCAN_DIV - 1));
  assign frame_end = sample && (row == 2'd3);

  // two-flop column synchronizer, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= 4'b1111;
      col_s2 <= 4'b1111;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
    end
  end

  // free-running dwell divider and row pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      row <= '0;
    end else if (sample) begin
      div <= '0;
      row <= row + 2'd1;
    end else begin
      div <= div + 16'd1;
    end
  end

  // count low columns in this row and merge with the frame so far
  always_comb begin
    lows = ~col_s2;
    rcnt = '0;
    rcol = '0;
    for (int c = 0; c < 4; c++) begin
      rcnt = rcnt + {2'b0, lows[c]};
      if (lows[c]) rcol = 2'(c);
    end
    base_n    = (row == 2'd0) ? 2'd0 : acc_n;
    base_code = (row == 2'd0) ? 4'd0 : acc_code;
    sum_n     = {1'b0, base_n} + rcnt;
    tot_n     = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    f_code    = (rcnt == 3'd1) ? key_map(row, rcol) : base_code;
    f_key     = (tot_n == 2'd1);
  end

  // frame accumulator: 0, 1 or "many" low bits seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_n    <= '0;
      acc_code <= '0;
    end else if (sample) begin
      acc_n    <= tot_n;
      acc_code <= f_code;
    end
  end

  // debounce state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
    end
  end

  // debounce next-state, evaluated once per frame
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cand_nx    = cand;
    accept     = 1'b0;
    release_ok = 1'b0;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (f_key) begin
            state_nx = DEB;
            cand_nx  = f_code;
            cnt_nx   = 4'd1;
          end
        end
        DEB: begin
          if (!f_key) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
          end else if (f_code != cand) begin
            cand_nx = f_code;
            cnt_nx  = 4'd1;
          end else begin
            cnt_nx = cnt + 4'd1;
            if (cnt + 4'd1 == 4'(DEBOUNCE_CNT)) begin
              state_nx = PRESSED;
              accept   = 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!f_key) begin
            state_nx = REL;
            cnt_nx   = 4'd1;
          end
        end
        REL: begin
          if (f_key) begin
            state_nx = PRESSED;
          end else begin
            cnt_nx = cnt + 4'd1;
            if (cnt + 4'd1 == 4'(DEBOUNCE_CNT)) begin
              state_nx   = IDLE;
              cnt_nx     = 4'd0;
              release_ok = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // registered outputs follow accept/release by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= cand;
        key_down <= 1'b1;
      end else if (release_ok) begin
        key_down <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: keypad model plus
// frame-level press/release reference.
module tb_keypad_scan_debounce;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FR = 4 * SD;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] held = '0;
  int errors = 0;
  int checks = 0;
  int k = 0;
  int dut_pulses = 0;
  int p0;

  int         codes[16] = '{1, 2, 3, 10, 4, 5, 6, 11,
                            7, 8, 9, 12, 14, 0, 13, 15};
  logic [3:0] rows_exp[4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  bit         m_down;
  bit         m_valid;
  int         m_run;
  int         m_rel;
  int         m_cand;
  logic [3:0] m_code;

  keypad_scan_debounce #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CNT(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .col_in(col_in),
    .row_out(row_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_down(key_down)
  );

  always #5 clk = ~clk;

  // physical keypad: a held key pulls its column low while its row is driven
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)",
               tag, got, exp, $time, k);
    end
  endtask

  function automatic void model_reset();
    m_down  = 0;
    m_valid = 0;
    m_run   = 0;
    m_rel   = 0;
    m_cand  = 0;
    m_code  = 4'd0;
  endfunction

  function automatic void model_frame();
    int n;
    int kc;
    bit key;
    n  = $countones(held);
    kc = 0;
    for (int i = 0; i < 16; i++) if (held[i]) kc = codes[i];
    key = (n == 1);
    if (!m_down) begin
      if (key) begin
        if (m_run > 0 && kc == m_cand) m_run++;
        else begin
          m_cand = kc;
          m_run  = 1;
        end
        if (m_run == DB) begin
          m_down  = 1;
          m_valid = 1;
          m_code  = 4'(m_cand);
          m_rel   = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (key) m_rel = 0;
      else begin
        m_rel++;
        if (m_rel == DB) begin
          m_down = 0;
          m_run  = 0;
          m_rel  = 0;
        end
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    k++;
    m_valid = 0;
    if (k % FR == 0) model_frame();
    if (key_valid) dut_pulses++;
    chk("row_out", row_out, rows_exp[(k / SD) % 4]);
    chk("key_valid", key_valid, m_valid);
    chk("key_down", key_down, m_down);
    chk("key_code", key_code, m_code);
  endtask

  task automatic frames(input int n);
    repeat (n * FR) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_row", row_out, 4'hE);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_down", key_down, 1'b0);
    chk("rst_code", key_code, 4'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    frames(2);

    // '8' held: single accept, then held for 10 more frames
    p0 = dut_pulses;
    held = 16'h1 << 9;
    frames(13);
    chk("one_pulse_8", dut_pulses - p0, 1);
    chk("code_8", key_code, 4'd8);
    held = '0;
    frames(4);

    // '+' broken run then 3-frame run
    p0 = dut_pulses;
    held = 16'h1 << 3;
    frames(1);
    held = '0;
    frames(1);
    held = 16'h1 << 3;
    frames(2);
    chk("plus_early", dut_pulses - p0, 0);
    frames(1);
    chk("plus_pulse", dut_pulses - p0, 1);
    chk("code_plus", key_code, 4'd10);
    held = '0;
    frames(4);

    // ghost '1' + '5'
    p0 = dut_pulses;
    held = (16'h1 << 0) | (16'h1 << 5);
    frames(5);
    chk("ghost_pulse", dut_pulses - p0, 0);
    chk("ghost_code", key_code, 4'd10);
    held = '0;
    frames(1);

    // '=' with short release bounce
    p0 = dut_pulses;
    held = 16'h1 << 14;
    frames(3);
    held = '0;
    frames(2);
    held = 16'h1 << 14;
    frames(2);
    chk("eq_still_down", key_down, 1'b1);
    chk("eq_one_pulse", dut_pulses - p0, 1);
    held = '0;
    frames(3);
    chk("eq_released", key_down, 1'b0);
    held = 16'h1 << 14;
    frames(3);
    chk("eq_two_pulses", dut_pulses - p0, 2);
    chk("code_eq", key_code, 4'd13);
    held = '0;
    frames(4);

    // '7' interrupted by reset mid-frame
    held = 16'h1 << 8;
    frames(2);
    repeat (5) cycle();
    do_reset();
    p0 = dut_pulses;
    frames(2);
    chk("seven_early", dut_pulses - p0, 0);
    frames(1);
    chk("seven_pulse", dut_pulses - p0, 1);
    chk("code_7", key_code, 4'd7);
    held = '0;
    frames(4);

    // random keys, ghosts and gaps
    repeat (60) begin
      int sel;
      int a;
      int b;
      sel = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      if (sel == 0) held = '0;
      else if (sel == 3) held = (16'h1 << a) | (16'h1 << b);
      else held = 16'h1 << a;
      frames($urandom_range(1, 4));
    end
    held = '0;
    frames(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
